pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
// - Owns the program counter and the instruction-fetch stage; consumes the taken-branch redirect (PcSel/BrPC) from EX.
// - Issues one-outstanding requests to instruction memory and buffers {pc,instr} pairs in a small FIFO feeding IF/ID.
// - On redirect: flushes younger work, discards stale memory responses and restarts fetch at the target.
// PARAMETERS
// - PC_W      9  PC width in bits; all PC arithmetic is modulo 2^PC_W
// - RESET_PC  0  PC value loaded on reset (PC_W bits, word aligned)
// - FB_DEPTH  2  fetch-buffer entries (power of two, >=2)
// PORTS
// - clk            in   1     clock; all state updates on posedge
// - reset          in   1     synchronous, active-high reset
// - redirect_i     in   1     branch/jump taken in EX (PcSel)
// - redirect_pc_i  in   32    target (BrPC); bits [31:PC_W] and [1:0] ignored
// - flush_o        out  1     kill IF/ID and ID/EX this cycle (= redirect_i & ~reset)
// - imem_req_o     out  1     fetch request valid
// - imem_addr_o    out  PC_W  fetch address, [1:0] always 0
// - imem_gnt_i     in   1     request accepted this cycle
// - imem_rvalid_i  in   1     response data valid (>=1 cycle after gnt, in order)
// - imem_rdata_i   in   32    instruction word
// - if_valid_o     out  1     buffer head valid toward decode
// - if_pc_o        out  PC_W  PC of buffer head
// - if_instr_o     out  32    instruction of buffer head
// - if_ready_i     in   1     decode accepts head (low = hazard stall)
// - perf_redirects_o out 32   redirect count (see CONFIGURATION)
// - perf_stalls_o  out  32    cycles with if_valid_o & ~if_ready_i
// BEHAVIOUR
// - Reset: pc_q=RESET_PC, FIFO empty, state=IDLE, all outputs 0, counters 0; in-flight data is dropped.
// - States: IDLE (none outstanding), WAIT (granted, awaiting rvalid), DRAIN (granted req killed by redirect).
// - IDLE: imem_req_o=1 when FIFO free slots>0 and ~redirect_i; imem_addr_o=pc_q. On gnt: pc_q<=pc_q+4, ->WAIT.
// - Address stays stable while req is high and ungranted; only redirect may withdraw it.
// - WAIT: on rvalid push {pc of request, rdata} to FIFO, ->IDLE; a new req may issue in the same cycle.
// - DRAIN: on rvalid drop data, ->IDLE; no request issued while in DRAIN.
// - Redirect (any state): pc_q<={redirect_pc_i[PC_W-1:2],2'b00}; FIFO cleared; req deasserted this cycle; WAIT->DRAIN;
//   a concurrent rvalid is discarded; fetch resumes at target next cycle (or after drain).
// - FIFO pop when if_valid_o & if_ready_i; push and pop in the same cycle allowed when full.
// - Latency: gnt in cycle N, rvalid N+1 -> if_valid_o in N+2 (registered FIFO, no bypass).
// - Boundaries: pc_q+4 wraps to 0 at 2^PC_W; reset beats redirect; redirect beats stall;
//   rvalid in IDLE (spurious) is ignored; FIFO never overflows (req gated on free slots counting outstanding).
// CONFIGURATION
// - FETCH_PERF_EN defined: perf_redirects_o increments per redirect cycle, perf_stalls_o per stall cycle;
//   both saturate at 32'hFFFF_FFFF and are cleared by reset.
// - FETCH_PERF_EN undefined: counters not built, both ports tied to 32'b0.
// STRUCTURE
// - Package riscv_fetch_pkg: fetch_state_e {IDLE,WAIT,DRAIN}, fetch_entry_t struct {pc, instr}, INSTR_W=32.
// - Sub-module fetch_fifo: FB_DEPTH x fetch_entry_t, push/pop/clear, full/empty/count; sync reset.
// TESTING
// - Reset release, gnt every cycle, rvalid +1 -> addresses 0,4,8..., if_pc_o 0 first valid 2 cycles after first gnt.
// - if_ready_i=0 for 10 cycles -> FIFO fills to FB_DEPTH, req drops, no lost/duplicated pc, perf_stalls_o=10 (PERF_EN).
// - Redirect to 32'h40 while WAIT -> flush_o 1 cycle, next rvalid dropped, next req addr 9'h040, FIFO empty.
// - Redirect coincident with rvalid of pc 0x10 -> instr of 0x10 never appears on if_valid_o.
// - pc_q=9'h1FC with gnt -> next addr 9'h000; redirect_pc_i=32'hFFFF_F03 -> addr 9'h100.
// - reset asserted during WAIT -> outputs 0, stale rvalid next cycle ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared types for the instruction-fetch stage
package riscv_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // pc is held at full address width; the fetch stage uses the low PC_W bits
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small {pc,instr} buffer between fetch and decode
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               do_push;
    logic               do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // a full buffer still accepts a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);

    // pointer and occupancy bookkeeping; clear empties the buffer at once
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // entry storage needs no reset, occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push && !reset && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and fetch stage; FETCH_PERF_EN builds perf counters
module pc_fetch_ctrl
    import riscv_fetch_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              FB_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                flush_o,
    output logic                imem_req_o,
    output logic [PC_W-1:0]     imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [31:0]         imem_rdata_i,
    output logic                if_valid_o,
    output logic [PC_W-1:0]     if_pc_o,
    output logic [31:0]         if_instr_o,
    input  logic                if_ready_i,
    output logic [31:0]         perf_redirects_o,
    output logic [31:0]         perf_stalls_o
);

    localparam int CNT_W = $clog2(FB_DEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic [PC_W-1:0]    target_pc;
    logic               redir;
    logic               req;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    fetch_entry_t       head;
    fetch_entry_t       push_data;
    logic               unused_bits;

    // reset takes priority over a redirect arriving in the same cycle
    assign redir      = redirect_i & ~reset;
    assign target_pc  = {redirect_pc_i[PC_W-1:2], 2'b00};
    assign flush_o    = redir;
    assign imem_req_o = req;
    assign imem_addr_o = pc_q;
    assign if_valid_o = ~fifo_empty;
    assign if_pc_o    = head.pc[PC_W-1:0];
    assign if_instr_o = head.instr;
    assign pop        = if_valid_o & if_ready_i;
    assign push_data  = '{pc: ADDR_W'(req_pc_q), instr: imem_rdata_i};
    assign unused_bits = ^{redirect_pc_i[31:PC_W], redirect_pc_i[1:0],
                           head.pc[ADDR_W-1:PC_W], fifo_full};

    // next state, fetch request and buffer push; at most one request outstanding
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        req      = 1'b0;
        push     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = IDLE;
                    push    = ~redir;
                end else if (redir) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a slot must stay free for the response, so count this cycle's push and pop
        if (!reset && !redir &&
            (state_q == IDLE || (state_q == WAIT && imem_rvalid_i)) &&
            ((int'(fifo_count) + int'(push) - int'(pop)) < FB_DEPTH)) begin
            req = 1'b1;
            if (imem_gnt_i) begin
                pc_d     = pc_q + PC_W'(4);
                req_pc_d = pc_q;
                state_d  = WAIT;
            end
        end

        if (redir) begin
            pc_d = target_pc;
        end
    end

    // state, program counter and in-flight request pc
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FB_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redir),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] redirects_q;
    logic [31:0] stalls_q;

    // saturating redirect and decode-stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            redirects_q <= '0;
            stalls_q    <= '0;
        end else begin
            if (redir && redirects_q != 32'hFFFF_FFFF) begin
                redirects_q <= redirects_q + 32'd1;
            end
            if (if_valid_o && !if_ready_i && stalls_q != 32'hFFFF_FFFF) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign perf_redirects_o = redirects_q;
    assign perf_stalls_o    = stalls_q;
`else
    assign perf_redirects_o = 32'b0;
    assign perf_stalls_o    = 32'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - randomized bench with behavioural fetch model for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
    import riscv_fetch_pkg::*;

    localparam int PC_W     = 9;
    localparam int FB_DEPTH = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               redirect_i;
    logic [31:0]        redirect_pc_i;
    logic               flush_o;
    logic               imem_req_o;
    logic [PC_W-1:0]    imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [31:0]        imem_rdata_i;
    logic               if_valid_o;
    logic [PC_W-1:0]    if_pc_o;
    logic [31:0]        if_instr_o;
    logic               if_ready_i;
    logic [31:0]        perf_redirects_o;
    logic [31:0]        perf_stalls_o;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .PC_W     (PC_W),
        .RESET_PC (9'h000),
        .FB_DEPTH (FB_DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .flush_o          (flush_o),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_instr_o       (if_instr_o),
        .if_ready_i       (if_ready_i),
        .perf_redirects_o (perf_redirects_o),
        .perf_stalls_o    (perf_stalls_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [PC_W-1:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [PC_W-1:0] addr; int due; } rsp_t;

    // reference model: expected buffer contents, next fetch pc, outstanding request
    ent_t            q[$];
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_opc;
    bit              m_out;
    bit              m_drain;
    int              m_redirects;
    int              m_stalls;

    // memory model
    rsp_t            mq[$];
    int              cyc = 0;
    int              dmin = 1;
    int              dmax = 1;

    // last sampled DUT values, for hand-computed expectations
    logic            s_req, s_flush, s_valid, s_gnt;
    logic [PC_W-1:0] s_addr, s_pc;
    logic [PC_W-1:0] gnt_log[$];
    bit              seen10;

    function automatic logic [31:0] instr_of(input logic [PC_W-1:0] a);
        return {7'h55, a, 7'h2A, ~a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // one clock cycle: drive inputs, compare against model, then advance model
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                        input bit rdy, input int gmode, input bit spur);
        bit              rv, g, push, pop, req_e, flush_e;
        logic [31:0]     rd;
        logic [PC_W-1:0] a_cap;
        logic [PC_W-1:0] tgt;
        reset         = rst;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        if_ready_i    = rdy;
        rv = 1'b0;
        rd = $urandom;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv = 1'b1;
            rd = instr_of(mq[0].addr);
            void'(mq.pop_front());
        end else if (mq.size() == 0 && spur) begin
            rv = 1'b1;
        end
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        imem_gnt_i    = 1'b0;
        #1;
        flush_e = redir && !rst;
        pop     = (q.size() > 0) && rdy;
        push    = m_out && !m_drain && rv && !flush_e;
        req_e   = !rst && !flush_e && (!m_out || (rv && !m_drain)) &&
                  ((q.size() + int'(push) - int'(pop)) < FB_DEPTH);
        case (gmode)
            1:       g = imem_req_o;
            2:       g = imem_req_o && ($urandom_range(0, 2) != 0);
            default: g = 1'b0;
        endcase
        imem_gnt_i = g;
        @(negedge clk);
        a_cap   = imem_addr_o;
        s_req   = imem_req_o;
        s_flush = flush_o;
        s_valid = if_valid_o;
        s_addr  = imem_addr_o;
        s_pc    = if_pc_o;
        s_gnt   = g;
        if (if_valid_o === 1'b1 && if_pc_o == 9'h010) seen10 = 1'b1;
        check("flush", {31'd0, flush_o}, {31'd0, flush_e});
        check("req", {31'd0, imem_req_o}, {31'd0, req_e});
        if (req_e) check("addr", {23'd0, imem_addr_o}, {23'd0, m_pc});
        if (!rst) begin
            check("if_valid", {31'd0, if_valid_o}, {31'd0, q.size() > 0});
            if (q.size() > 0) begin
                check("if_pc", {23'd0, if_pc_o}, {23'd0, q[0].pc});
                check("if_instr", if_instr_o, q[0].instr);
            end
`ifdef FETCH_PERF_EN
            check("perf_redirects", perf_redirects_o, m_redirects);
            check("perf_stalls", perf_stalls_o, m_stalls);
`else
            check("perf_redirects", perf_redirects_o, 32'd0);
            check("perf_stalls", perf_stalls_o, 32'd0);
`endif
        end
        @(posedge clk);
        if (g) begin
            mq.push_back('{a_cap, cyc + $urandom_range(dmin, dmax)});
            gnt_log.push_back(a_cap);
        end
        if (rst) begin
            q.delete();
            mq.delete();
            m_pc = 9'h000;
            m_out = 1'b0;
            m_drain = 1'b0;
            m_redirects = 0;
            m_stalls = 0;
        end else begin
            if (q.size() > 0 && !rdy) m_stalls++;
            if (flush_e) m_redirects++;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{m_opc, rd});
            if (m_out && rv) begin
                m_out = 1'b0;
                m_drain = 1'b0;
            end
            if (flush_e) begin
                q.delete();
                tgt = rpc[PC_W-1:0];
                m_pc = {tgt[PC_W-1:2], 2'b00};
                if (m_out) m_drain = 1'b1;
            end else if (req_e && g) begin
                m_out = 1'b1;
                m_opc = m_pc;
                m_pc  = m_pc + 9'd4;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        int first_gnt, first_valid, base_stalls, n;
        bit got;
        reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0; if_ready_i = 1'b1;
        m_pc = '0; m_opc = '0; m_out = 1'b0; m_drain = 1'b0; m_redirects = 0; m_stalls = 0;
        seen10 = 1'b0;
        @(posedge clk); #1;

        // reset, then streaming fetch with grant every cycle and rvalid one cycle later
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        gnt_log.delete();
        first_gnt = -1; first_valid = -1;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 1, 0);
            if (i == 0) begin
                check("reset_valid", {31'd0, s_valid}, 32'd0);
                check("reset_addr", {23'd0, s_addr}, 32'd0);
            end
            if (s_gnt && first_gnt < 0) first_gnt = i;
            if (s_valid && first_valid < 0) begin
                first_valid = i;
                check("first_if_pc", {23'd0, s_pc}, 32'd0);
            end
        end
        check("gnt_addr0", {23'd0, gnt_log[0]}, 32'h000);
        check("gnt_addr1", {23'd0, gnt_log[1]}, 32'h004);
        check("gnt_addr2", {23'd0, gnt_log[2]}, 32'h008);
        check("first_valid_latency", first_valid - first_gnt, 2);

        // decode stalls for 10 cycles: buffer fills and request drops
        base_stalls = int'(perf_stalls_o);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0);
        check("stall_req_low", {31'd0, s_req}, 32'd0);
        check("stall_valid", {31'd0, s_valid}, 32'd1);
`ifdef FETCH_PERF_EN
        check("perf_stalls_10", int'(perf_stalls_o) - base_stalls, 10);
`endif
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0);

        // redirect to 0x40 while a request is outstanding
        dmin = 3; dmax = 3;
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 32'h40, 1, 0, 0);
        check("redir_flush", {31'd0, s_flush}, 32'd1);
        got = 1'b0;
        n = 0;
        while (!got && n < 8) begin
            step(0, 0, 0, 1, 1, 0);
            if (n == 0) check("redir_fifo_empty", {31'd0, s_valid}, 32'd0);
            if (s_req) begin
                got = 1'b1;
                check("redir_addr", {23'd0, s_addr}, 32'h040);
            end
            n++;
        end
        check("redir_req_seen", {31'd0, got}, 32'd1);

        // redirect coincident with rvalid of pc 0x10
        dmin = 1; dmax = 1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 1, 32'h10, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        seen10 = 1'b0;
        step(0, 1, 32'h80, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0);
        check("no_stale_0x10", {31'd0, seen10}, 32'd0);

        // target truncation and pc wrap
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 1, 32'hFFFF_FF03, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("trunc_addr", {23'd0, s_addr}, 32'h100);
        step(0, 1, 32'h1FC, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        check("wrap_gnt_addr", {23'd0, s_addr}, 32'h1FC);
        step(0, 0, 0, 1, 0, 0);
        check("wrap_req", {31'd0, s_req}, 32'd1);
        check("wrap_addr", {23'd0, s_addr}, 32'h000);

        // reset during an outstanding request; stale rvalid afterwards
        dmin = 3; dmax = 3;
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        check("rst_wait_valid", {31'd0, s_valid}, 32'd0);
        check("rst_wait_addr", {23'd0, s_addr}, 32'h000);
        step(0, 0, 0, 1, 0, 0);
        check("stale_ignored", {31'd0, s_valid}, 32'd0);

        // randomized traffic
        dmin = 1; dmax = 3;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom,
                 $urandom_range(0, 3) != 0,
                 2,
                 $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
